// File: rtl/clock_pkg.sv
// Shared types, segment patterns, field limits and BCD helpers for the
// 24-hour wall clock.
package clock_pkg;

    // One BCD digit
    typedef logic [3:0] bcd_t;

    // A two-digit time field (tens, units)
    typedef struct packed {
        bcd_t tens;
        bcd_t units;
    } field_t;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Largest legal value of each field
    localparam logic [6:0] SEC_MAX = 7'd59;
    localparam logic [6:0] MIN_MAX = 7'd59;
    localparam logic [6:0] HR_MAX  = 7'd23;

    // Bit positions of the three keys inside the key vector
    localparam int KEY_SEC = 0;
    localparam int KEY_MIN = 1;
    localparam int KEY_HR  = 2;
    localparam int KEY_NUM = 3;

    localparam field_t FIELD_ZERO = {4'd0, 4'd0};

    // Binary value of a two-digit BCD field
    function automatic logic [6:0] fieldValue(input field_t f);
        return ({3'd0, f.tens} * 7'd10) + {3'd0, f.units};
    endfunction

    // True when the field sits on its wrap value
    function automatic logic fieldAtMax(input field_t f, input logic [6:0] maxVal);
        return (fieldValue(f) == maxVal);
    endfunction

    // Field + 1 in BCD, wrapping to 00 after maxVal
    function automatic field_t fieldInc(input field_t f, input logic [6:0] maxVal);
        field_t r;
        if (fieldAtMax(f, maxVal)) begin
            r = FIELD_ZERO;
        end else if (f.units == 4'd9) begin
            r.tens  = f.tens + 4'd1;
            r.units = 4'd0;
        end else begin
            r.tens  = f.tens;
            r.units = f.units + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/top_clock_seg7_decoder.sv
// BCD digit to active-high 7-segment pattern; non-BCD codes blank the digit.
module seg7_decoder
    import clock_pkg::*;
(
    input  bcd_t       digit,
    output logic [6:0] seg
);

    // Pure lookup from digit value to segment pattern
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/top_clock.sv
// 24-hour HH:MM:SS wall clock with debounced set keys and six 7-segment
// digit outputs.  Time lives in BCD registers; the displays are decoded
// straight from those registers so a reset shows 00:00:00 immediately.
module top_clock
    import clock_pkg::*;
#(
    parameter int TICKS_PER_SEC   = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       keyHr,
    input  logic       keyMin,
    input  logic       keySec,
    output logic [6:0] hrSegL,
    output logic [6:0] hrSegH,
    output logic [6:0] minSegL,
    output logic [6:0] minSegH,
    output logic [6:0] secSegL,
    output logic [6:0] secSegH
);

    localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [KEY_NUM-1:0] keyRaw_s;
    logic [KEY_NUM-1:0] keySync1_r;
    logic [KEY_NUM-1:0] keySync2_r;
    logic [KEY_NUM-1:0] keyStable_r;
    logic [KEY_NUM-1:0] keyPress_r;
    logic [DB_W-1:0]    dbCnt_r [KEY_NUM];

    logic [PRE_W-1:0]   preCnt_r;
    logic               tick_s;

    field_t sec_r;
    field_t min_r;
    field_t hr_r;
    field_t secNext_s;
    field_t minNext_s;
    field_t hrNext_s;
    logic   secCarry_s;
    logic   minCarry_s;

    assign keyRaw_s = {keyHr, keyMin, keySec};

    // Two-flop synchronizer bringing the asynchronous keys into clk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            keySync1_r <= 3'b000;
            keySync2_r <= 3'b000;
        end else begin
            keySync1_r <= keyRaw_s;
            keySync2_r <= keySync1_r;
        end
    end

    // Debounce: a new level must persist DEBOUNCE_CYCLES samples; accepting a
    // high level emits a single press pulse, so a held key never repeats
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            keyStable_r <= 3'b000;
            keyPress_r  <= 3'b000;
            for (int k = 0; k < KEY_NUM; k++) begin
                dbCnt_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < KEY_NUM; k++) begin
                if (keySync2_r[k] == keyStable_r[k]) begin
                    dbCnt_r[k]    <= '0;
                    keyPress_r[k] <= 1'b0;
                end else if (dbCnt_r[k] == DB_LAST) begin
                    dbCnt_r[k]     <= '0;
                    keyStable_r[k] <= keySync2_r[k];
                    keyPress_r[k]  <= keySync2_r[k];
                end else begin
                    dbCnt_r[k]    <= dbCnt_r[k] + DB_W'(1);
                    keyPress_r[k] <= 1'b0;
                end
            end
        end
    end

    assign tick_s = (preCnt_r == PRE_LAST);

    // Prescaler: free-running 0..TICKS_PER_SEC-1, untouched by key presses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            preCnt_r <= '0;
        end else if (tick_s) begin
            preCnt_r <= '0;
        end else begin
            preCnt_r <= preCnt_r + PRE_W'(1);
        end
    end

    // Next-time logic: a press owns its field for the cycle and swallows any
    // tick carry into it; lower fields still follow the tick
    always_comb begin
        secNext_s  = sec_r;
        minNext_s  = min_r;
        hrNext_s   = hr_r;
        secCarry_s = 1'b0;
        minCarry_s = 1'b0;

        if (keyPress_r[KEY_SEC]) begin
            secNext_s = fieldInc(sec_r, SEC_MAX);
        end else if (tick_s) begin
            secNext_s  = fieldInc(sec_r, SEC_MAX);
            secCarry_s = fieldAtMax(sec_r, SEC_MAX);
        end else begin
            secNext_s = sec_r;
        end

        if (keyPress_r[KEY_MIN]) begin
            minNext_s = fieldInc(min_r, MIN_MAX);
        end else if (secCarry_s) begin
            minNext_s  = fieldInc(min_r, MIN_MAX);
            minCarry_s = fieldAtMax(min_r, MIN_MAX);
        end else begin
            minNext_s = min_r;
        end

        if (keyPress_r[KEY_HR]) begin
            hrNext_s = fieldInc(hr_r, HR_MAX);
        end else if (minCarry_s) begin
            hrNext_s = fieldInc(hr_r, HR_MAX);
        end else begin
            hrNext_s = hr_r;
        end
    end

    // Time registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_r <= FIELD_ZERO;
            min_r <= FIELD_ZERO;
            hr_r  <= FIELD_ZERO;
        end else begin
            sec_r <= secNext_s;
            min_r <= minNext_s;
            hr_r  <= hrNext_s;
        end
    end

    seg7_decoder uHrH  (.digit(hr_r.tens),   .seg(hrSegH));
    seg7_decoder uHrL  (.digit(hr_r.units),  .seg(hrSegL));
    seg7_decoder uMinH (.digit(min_r.tens),  .seg(minSegH));
    seg7_decoder uMinL (.digit(min_r.units), .seg(minSegL));
    seg7_decoder uSecH (.digit(sec_r.tens),  .seg(secSegH));
    seg7_decoder uSecL (.digit(sec_r.units), .seg(secSegL));

endmodule

// File: tb/tb_top_clock.sv
// Self-checking bench for top_clock: a time-of-day reference model driven by
// the same key waveforms, checked against all six segment outputs.
module tb_top_clock;

    localparam int T = 100;   // system cycles per second tick
    localparam int D = 4;     // debounce length

    logic       clk = 1'b0;
    logic       rst;
    logic       keyHr;
    logic       keyMin;
    logic       keySec;
    logic [6:0] hrSegL;
    logic [6:0] hrSegH;
    logic [6:0] minSegL;
    logic [6:0] minSegH;
    logic [6:0] secSegL;
    logic [6:0] secSegH;

    top_clock #(.TICKS_PER_SEC(T), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst),
        .keyHr(keyHr), .keyMin(keyMin), .keySec(keySec),
        .hrSegL(hrSegL), .hrSegH(hrSegH),
        .minSegL(minSegL), .minSegH(minSegH),
        .secSegL(secSegL), .secSegH(secSegH)
    );

    always #5 clk = ~clk;

    int cmpCnt = 0;
    int errCnt = 0;

    // Reference model: plain hour/minute/second integers
    int mh, mm, ms;
    int ph;              // clock edges since reset release
    int edgeN = 0;       // absolute edge counter
    int acc [3];         // accepted key level (0 hr, 1 min, 2 sec)
    int run [3];         // consecutive samples differing from accepted level
    int dueQ [3][$];     // edges at which a press lands on the time

    logic [6:0] segTab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic logic [6:0] segOf(input int d);
        return segTab[d];
    endfunction

    task automatic modelReset();
        mh = 0; mm = 0; ms = 0; ph = 0;
        for (int k = 0; k < 3; k++) begin
            acc[k] = 0;
            run[k] = 0;
            dueQ[k].delete();
        end
    endtask

    // One clock: advance the model on the rising edge, return at the falling edge
    task automatic cycle();
        int  kin [3];
        bit  tick, prH, prM, prS, cS, cM;
        @(posedge clk);
        edgeN++;
        if (!rst) begin
            kin[0] = int'(keyHr); kin[1] = int'(keyMin); kin[2] = int'(keySec);
            ph++;
            tick = (ph % T == 0);
            prH = 1'b0; prM = 1'b0; prS = 1'b0;
            if (dueQ[0].size() > 0 && dueQ[0][0] == edgeN) begin prH = 1'b1; void'(dueQ[0].pop_front()); end
            if (dueQ[1].size() > 0 && dueQ[1][0] == edgeN) begin prM = 1'b1; void'(dueQ[1].pop_front()); end
            if (dueQ[2].size() > 0 && dueQ[2][0] == edgeN) begin prS = 1'b1; void'(dueQ[2].pop_front()); end
            cS = tick && !prS && ms == 59;
            if (prS || tick) ms = (ms + 1) % 60;
            cM = cS && !prM && mm == 59;
            if (prM || cS) mm = (mm + 1) % 60;
            if (prH || cM) mh = (mh + 1) % 24;
            // sync + debounce + press pulse: press lands 3 edges after the
            // D-th consecutive high sample
            for (int k = 0; k < 3; k++) begin
                if (kin[k] != acc[k]) begin
                    run[k]++;
                    if (run[k] == D) begin
                        acc[k] = kin[k];
                        run[k] = 0;
                        if (acc[k] == 1) dueQ[k].push_back(edgeN + 3);
                    end
                end else begin
                    run[k] = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        cmpCnt++;
        assert (obs === exp) else begin
            errCnt++;
            $error("FAIL %s: observed %h expected %h (model %0d:%0d:%0d)", tag, obs, exp, mh, mm, ms);
        end
    endtask

    task automatic checkTime(input string tag);
        chk({tag, " hrH"},  hrSegH,  segOf(mh / 10));
        chk({tag, " hrL"},  hrSegL,  segOf(mh % 10));
        chk({tag, " minH"}, minSegH, segOf(mm / 10));
        chk({tag, " minL"}, minSegL, segOf(mm % 10));
        chk({tag, " secH"}, secSegH, segOf(ms / 10));
        chk({tag, " secL"}, secSegL, segOf(ms % 10));
    endtask

    // Advance until the edge on which a tick has just been applied
    task automatic alignTick();
        cycle();
        for (int g = 0; g < T && (ph % T) != 0; g++) cycle();
    endtask

    // One 10-cycle press slot; slot i presses each key whose count exceeds i
    task automatic pressSlot(input int nh, input int nm, input int ns, input int i);
        keyHr = (i < nh); keyMin = (i < nm); keySec = (i < ns);
        runCycles(5);
        keyHr = 1'b0; keyMin = 1'b0; keySec = 1'b0;
        runCycles(5);
    endtask

    // Drive the keys until the time just after a tick equals hh:mm:ss
    task automatic setTime(input int th, input int tm, input int ts);
        int pre, ph2, pm2, ps2, nh, nm, ns, ds;
        bit done;
        done = 1'b0;
        pre = (th * 3600 + tm * 60 + ts + 86399) % 86400;
        ph2 = pre / 3600; pm2 = (pre / 60) % 60; ps2 = pre % 60;
        alignTick();
        for (int it = 0; it < 60 && !done; it++) begin
            if (mh == th && mm == tm && ms == ts) begin
                done = 1'b1;
            end else begin
                nh = (ph2 - mh + 24) % 24; if (nh > 8) nh = 8;
                nm = (pm2 - mm + 60) % 60; if (nm > 8) nm = 8;
                ds = (ps2 - ms + 60) % 60;
                ns = (ds > 8) ? 8 : ds;
                if (ns < ds && (ms + ns) % 60 == 59) ns--;
                for (int i = 0; i < 8; i++) pressSlot(nh, nm, ns, i);
                alignTick();
            end
        end
        cmpCnt++;
        assert (done) else begin
            errCnt++;
            $error("FAIL setTime: observed not reached expected %0d:%0d:%0d", th, tm, ts);
        end
    endtask

    initial begin
        int hold [3];
        logic lvl [3];
        rst = 1'b1; keyHr = 1'b0; keyMin = 1'b0; keySec = 1'b0;
        modelReset();

        // Reset held 20 ns
        #3;
        chk("rstHold secL", secSegL, 7'h3F);
        chk("rstHold hrH",  hrSegH,  7'h3F);
        @(negedge clk);
        @(negedge clk);
        checkTime("inReset");
        rst = 1'b0;

        // Nothing moves until the first tick, which lands T cycles after release
        runCycles(T - 1);
        checkTime("preTick");
        chk("preTick secL", secSegL, 7'h3F);
        cycle();
        checkTime("firstTick");
        chk("firstTick secL", secSegL, 7'h06);

        // Short glitches are ignored, a long hold gives exactly one minute step
        keyMin = 1'b1; cycle(); keyMin = 1'b0; runCycles(6);
        keyMin = 1'b1; runCycles(2); keyMin = 1'b0; runCycles(6);
        keyMin = 1'b1; runCycles(3); keyMin = 1'b0; runCycles(6);
        checkTime("glitch");
        chk("glitch minL", minSegL, 7'h3F);
        keyMin = 1'b1; runCycles(20);
        checkTime("hold");
        chk("hold minL", minSegL, 7'h06);
        keyMin = 1'b0; runCycles(10);
        checkTime("release");
        chk("release minL", minSegL, 7'h06);

        // Free run from reset: 600 ticks -> 00:10:00
        rst = 1'b1; modelReset();
        runCycles(2);
        rst = 1'b0;
        runCycles(600 * T);
        checkTime("freeRun");
        chk("freeRun minH", minSegH, 7'h06);
        chk("freeRun minL", minSegL, 7'h3F);
        chk("freeRun secH", secSegH, 7'h3F);
        chk("freeRun secL", secSegL, 7'h3F);

        // Day rollover on a single edge
        setTime(23, 59, 59);
        checkTime("at235959");
        chk("at235959 hrH", hrSegH, 7'h5B);
        alignTick();
        checkTime("rollover");
        chk("rollover hrH", hrSegH, 7'h3F);
        chk("rollover secL", secSegL, 7'h3F);

        // Minute key wraps without carrying into hours
        setTime(0, 59, 30);
        keyMin = 1'b1; runCycles(6); keyMin = 1'b0; runCycles(14);
        checkTime("minWrap");
        chk("minWrap minH", minSegH, 7'h3F);
        chk("minWrap hrL",  hrSegL,  7'h3F);
        chk("minWrap secH", secSegH, 7'h4F);

        // Second key wraps without carrying into minutes
        setTime(0, 0, 59);
        keySec = 1'b1; runCycles(6); keySec = 1'b0; runCycles(14);
        checkTime("secWrap");
        chk("secWrap secH", secSegH, 7'h3F);
        chk("secWrap minL", minSegL, 7'h3F);

        // Random key activity, including presses colliding with ticks
        for (int k = 0; k < 3; k++) begin hold[k] = 0; lvl[k] = 1'b0; end
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (hold[k] == 0) begin
                    lvl[k]  = 1'($urandom_range(0, 1));
                    hold[k] = int'($urandom_range(1, 8));
                end
                hold[k]--;
            end
            keyHr = lvl[0]; keyMin = lvl[1]; keySec = lvl[2];
            cycle();
            if (c % 7 == 0) checkTime("random");
        end
        keyHr = 1'b0; keyMin = 1'b0; keySec = 1'b0;
        runCycles(20);
        checkTime("randomEnd");

        // Asynchronous reset between edges
        setTime(12, 34, 56);
        checkTime("at123456");
        runCycles(3);
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkTime("asyncRst");
        chk("asyncRst hrL", hrSegL, 7'h3F);
        @(negedge clk);
        cycle(); cycle();
        rst = 1'b0;
        runCycles(T - 1);
        chk("restart pre secL", secSegL, 7'h3F);
        cycle();
        checkTime("restart");
        chk("restart secL", secSegL, 7'h06);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
        $finish;
    end

endmodule
